// File: rtl/mc_pkg.sv
// ============================================================================
// Module   : mc_pkg
// Purpose  : State, opcode, ALUOp and datapath-select encodings for the
//            multicycle RV32I controller. Optional macro: MC_ILLEGAL_TRAP_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_REG   = 2'b10;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // funct7b5 selects sub only for register-register ops; addi has no such bit
    function automatic logic [2:0] alu_decode(
        input aluop_t     alu_op,
        input logic [2:0] funct3,
        input logic       op5,
        input logic       funct7b5
    );
        logic [2:0] ctl;
        ctl = ALU_ADD;
        case (alu_op)
            ALUOP_SUB: ctl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  ctl = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  ctl = ALU_SLT;
                    3'b110:  ctl = ALU_OR;
                    3'b111:  ctl = ALU_AND;
                    default: ctl = ALU_ADD;
                endcase
            end
            default: ctl = ALU_ADD;
        endcase
        return ctl;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mc_mainfsm.sv
// ============================================================================
// Module   : mc_mainfsm
// Purpose  : Main control FSM: state register, next state, Moore outputs.
//            Optional macro: MC_ILLEGAL_TRAP_EN (unknown opcodes trap).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_mainfsm
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    output state_t     state,
    output aluop_t     alu_op,
    output logic       branch,
    output logic       pc_update,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       reg_write,
    output logic       illegal_op
);

    state_t state_q;
    state_t state_d;

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    assign state = state_q;

    always_comb begin
        state_d    = S_FETCH;
        alu_op     = ALUOP_ADD;
        branch     = 1'b0;
        pc_update  = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        result_src = RES_ALUOUT;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_REG;
        reg_write  = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_write   = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURESULT;
                pc_update  = 1'b1;
                state_d    = S_DECODE;
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTER;
                    OP_ITYPE:     state_d = S_EXECUTEI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
`ifdef MC_ILLEGAL_TRAP_EN
                    default:      state_d = S_TRAP;
`else
                    default:      state_d = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: begin
                alu_src_a = SRCA_REG;
                alu_src_b = SRCB_IMM;
                state_d   = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = RES_DATA;
                reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
            end
            S_EXECUTER: begin
                alu_src_a = SRCA_REG;
                alu_op    = ALUOP_FUNCT;
                state_d   = S_ALUWB;
            end
            S_EXECUTEI: begin
                alu_src_a = SRCA_REG;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_FUNCT;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
            end
            S_BEQ: begin
                alu_src_a = SRCA_REG;
                alu_op    = ALUOP_SUB;
                branch    = 1'b1;
            end
            S_JAL: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_FOUR;
                pc_update = 1'b1;
                state_d   = S_ALUWB;
            end
`ifdef MC_ILLEGAL_TRAP_EN
            S_TRAP: begin
                state_d = S_TRAP;
            end
`endif
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

`ifdef MC_ILLEGAL_TRAP_EN
    logic illegal_q;

    always_ff @(posedge clk) begin
        if (reset)
            illegal_q <= 1'b0;
        else if (state_d == S_TRAP)
            illegal_q <= 1'b1;
    end

    assign illegal_op = illegal_q;
`else
    assign illegal_op = 1'b0;
`endif

endmodule

`default_nettype wire

// File: rtl/multicycle_controller.sv
// ============================================================================
// Module   : multicycle_controller
// Purpose  : Multicycle RV32I control unit: main FSM plus ALU/immediate
//            decode. Optional macro: MC_ILLEGAL_TRAP_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_controller
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       RegWrite,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic [3:0] State,
    output logic       IllegalOp
);

    state_t state;
    aluop_t alu_op;
    logic   branch;
    logic   pc_update;
    logic   mem_write;
    logic   ir_write;
    logic   reg_write;

    mc_mainfsm u_mainfsm (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .state      (state),
        .alu_op     (alu_op),
        .branch     (branch),
        .pc_update  (pc_update),
        .adr_src    (AdrSrc),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .result_src (ResultSrc),
        .alu_src_a  (ALUSrcA),
        .alu_src_b  (ALUSrcB),
        .reg_write  (reg_write),
        .illegal_op (IllegalOp)
    );

    assign State      = state;
    assign ALUControl = alu_decode(alu_op, funct3, op[5], funct7b5);

    always_comb begin
        case (op)
            OP_SW:   ImmSrc = IMM_S;
            OP_BEQ:  ImmSrc = IMM_B;
            OP_JAL:  ImmSrc = IMM_J;
            default: ImmSrc = IMM_I;
        endcase
    end

    // State still shows its pre-reset value during reset; keep enables quiet
    assign PCWrite  = ~reset & (pc_update | (branch & Zero));
    assign IRWrite  = ~reset & ir_write;
    assign RegWrite = ~reset & reg_write;
    assign MemWrite = ~reset & mem_write;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_controller.sv
// ============================================================================
// Module   : tb_multicycle_controller
// Purpose  : Randomized self-checking bench against a per-instruction
//            cycle-schedule model. Honors MC_ILLEGAL_TRAP_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_controller;
    import mc_pkg::*;

    localparam int C_LW  = 0;
    localparam int C_SW  = 1;
    localparam int C_R   = 2;
    localparam int C_I   = 3;
    localparam int C_BEQ = 4;
    localparam int C_JAL = 5;
    localparam int C_ILL = 6;

    typedef struct packed {
        logic       pcw;
        logic       adr;
        logic       memw;
        logic       irw;
        logic [1:0] res;
        logic [1:0] sa;
        logic [1:0] sb;
        logic       regw;
        logic [1:0] imm;
        logic [2:0] aluc;
        logic [3:0] st;
        logic       ill;
    } ctl_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, IllegalOp;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic [3:0] State;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    multicycle_controller dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .Zero       (Zero),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .RegWrite   (RegWrite),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl),
        .State      (State),
        .IllegalOp  (IllegalOp)
    );

    function automatic ctl_t observed();
        ctl_t a;
        a = '{PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
              RegWrite, ImmSrc, ALUControl, State, IllegalOp};
        return a;
    endfunction

    function automatic logic [6:0] class_op(input int cls);
        case (cls)
            C_LW:    return 7'b0000011;
            C_SW:    return 7'b0100011;
            C_R:     return 7'b0110011;
            C_I:     return 7'b0010011;
            C_BEQ:   return 7'b1100011;
            C_JAL:   return 7'b1101111;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic int class_cycles(input int cls);
        case (cls)
            C_LW:    return 5;
            C_BEQ:   return 3;
            C_ILL:   return 2;
            default: return 4;
        endcase
    endfunction

    // ALU operation for arithmetic instructions, from funct3 and the sub bit
    function automatic logic [2:0] ref_alu(input int cls, input logic [2:0] f3, input logic f7);
        if (f3 == 3'b000) return (cls == C_R && f7) ? 3'b001 : 3'b000;
        if (f3 == 3'b010) return 3'b101;
        if (f3 == 3'b110) return 3'b011;
        if (f3 == 3'b111) return 3'b010;
        return 3'b000;
    endfunction

    // Expected controls in cycle k of an instruction of class cls
    function automatic ctl_t ref_ctl(input int cls, input int k, input logic [2:0] f3,
                                     input logic f7, input logic z, input logic [6:0] opc);
        ctl_t e;
        e = '0;
        if (opc == 7'b0100011)      e.imm = 2'b01;
        else if (opc == 7'b1100011) e.imm = 2'b10;
        else if (opc == 7'b1101111) e.imm = 2'b11;
        if (k == 0) begin
            e.irw = 1'b1; e.pcw = 1'b1; e.sb = 2'b10; e.res = 2'b10; e.st = 4'd0;
        end else if (k == 1) begin
            e.sa = 2'b01; e.sb = 2'b01; e.st = 4'd1;
        end else if ((cls == C_LW || cls == C_SW) && k == 2) begin
            e.sa = 2'b10; e.sb = 2'b01; e.st = S_MEMADR;
        end else if (cls == C_LW && k == 3) begin
            e.adr = 1'b1; e.st = S_MEMREAD;
        end else if (cls == C_LW) begin
            e.res = 2'b01; e.regw = 1'b1; e.st = S_MEMWB;
        end else if (cls == C_SW) begin
            e.adr = 1'b1; e.memw = 1'b1; e.st = S_MEMWRITE;
        end else if (cls == C_R && k == 2) begin
            e.sa = 2'b10; e.aluc = ref_alu(cls, f3, f7); e.st = S_EXECUTER;
        end else if (cls == C_I && k == 2) begin
            e.sa = 2'b10; e.sb = 2'b01; e.aluc = ref_alu(cls, f3, f7); e.st = S_EXECUTEI;
        end else if (cls == C_BEQ) begin
            e.sa = 2'b10; e.aluc = 3'b001; e.pcw = z; e.st = S_BEQ;
        end else if (cls == C_JAL && k == 2) begin
            e.sa = 2'b01; e.sb = 2'b10; e.pcw = 1'b1; e.st = S_JAL;
        end else if (cls == C_ILL) begin
            e.st = S_TRAP; e.ill = 1'b1;
        end else begin
            e.regw = 1'b1; e.st = S_ALUWB;
        end
        return e;
    endfunction

    // Entered just after a rising edge with the DUT in FETCH; leaves likewise.
    // zmode: 0/1 force Zero, anything else randomizes it per cycle.
    task automatic run_instr(input int cls, input logic [6:0] opc, input logic [2:0] f3,
                             input logic f7, input int zmode, input int ncyc);
        ctl_t e, a;
        op = opc; funct3 = f3; funct7b5 = f7;
        for (int k = 0; k < ncyc; k++) begin
            Zero = (zmode == 0) ? 1'b0 : (zmode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
            #1;
            e = ref_ctl(cls, k, f3, f7, Zero, opc);
            a = observed();
            total++;
            if (a !== e)
                $display("FAIL ctl cls=%0d cycle=%0d: actual=%h required=%h", cls, k, a, e);
            else
                passed++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; op = 7'b0000011; funct3 = 3'b000; funct7b5 = 1'b0; Zero = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({State, IllegalOp, PCWrite, IRWrite, RegWrite, MemWrite} !== 9'b0)
            $display("FAIL reset: actual state=%0d ill=%b pcw=%b irw=%b regw=%b memw=%b required all 0",
                     State, IllegalOp, PCWrite, IRWrite, RegWrite, MemWrite);
        else
            passed++;
        reset = 1'b0;
    endtask

    task automatic test_directed();
        run_instr(C_LW,  class_op(C_LW),  3'b010, 1'b0, 2, 5);
        run_instr(C_SW,  class_op(C_SW),  3'b010, 1'b0, 2, 4);
        run_instr(C_BEQ, class_op(C_BEQ), 3'b000, 1'b0, 1, 3);
        run_instr(C_BEQ, class_op(C_BEQ), 3'b000, 1'b0, 0, 3);
        run_instr(C_R,   class_op(C_R),   3'b000, 1'b1, 2, 4);
        run_instr(C_I,   class_op(C_I),   3'b000, 1'b1, 2, 4);
        run_instr(C_R,   class_op(C_R),   3'b010, 1'b0, 2, 4);
        run_instr(C_I,   class_op(C_I),   3'b110, 1'b0, 2, 4);
        run_instr(C_R,   class_op(C_R),   3'b111, 1'b1, 2, 4);
        run_instr(C_JAL, class_op(C_JAL), 3'b000, 1'b0, 2, 4);
    endtask

    task automatic test_random();
        for (int n = 0; n < 80; n++) begin
            int         cls;
            logic [6:0] opc;
`ifdef MC_ILLEGAL_TRAP_EN
            cls = $urandom_range(0, 5);
`else
            cls = $urandom_range(0, 6);
`endif
            opc = class_op(cls);
            if (cls == C_ILL) begin
                opc = 7'($urandom);
                while (opc == 7'b0000011 || opc == 7'b0100011 || opc == 7'b0110011 ||
                       opc == 7'b0010011 || opc == 7'b1100011 || opc == 7'b1101111)
                    opc = 7'($urandom);
            end
            run_instr(cls, opc, 3'($urandom), 1'($urandom), 2, class_cycles(cls));
        end
    endtask

    task automatic test_illegal();
`ifdef MC_ILLEGAL_TRAP_EN
        run_instr(C_ILL, 7'b0000000, 3'b000, 1'b0, 2, 6);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        total++;
        if (State !== 4'd0 || IllegalOp !== 1'b0)
            $display("FAIL trap_clear: actual state=%0d ill=%b required state=0 ill=0", State, IllegalOp);
        else
            passed++;
`else
        run_instr(C_ILL, 7'b0000000, 3'b000, 1'b0, 2, 2);
`endif
        run_instr(C_R, class_op(C_R), 3'b000, 1'b0, 2, 4);
    endtask

    task automatic test_reset_mid_memread();
        run_instr(C_LW, class_op(C_LW), 3'b010, 1'b0, 2, 3);
        reset = 1'b1;
        #1;
        total++;
        if (State !== S_MEMREAD || RegWrite !== 1'b0 || MemWrite !== 1'b0)
            $display("FAIL reset_memread_gate: actual state=%0d regw=%b memw=%b required state=%0d regw=0 memw=0",
                     State, RegWrite, MemWrite, S_MEMREAD);
        else
            passed++;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        total++;
        if (State !== 4'd0 || RegWrite !== 1'b0 || IRWrite !== 1'b1)
            $display("FAIL reset_memread_fetch: actual state=%0d regw=%b irw=%b required state=0 regw=0 irw=1",
                     State, RegWrite, IRWrite);
        else
            passed++;
        run_instr(C_SW, class_op(C_SW), 3'b010, 1'b0, 2, 4);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_illegal();
        test_reset_mid_memread();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
